conv1d_engine: RTL

Streaming 1-D convolution layer for the wake-word datapath. It buffers one input frame of `FRAME_SIZE` multi-channel vectors, then computes `NUM_FILTERS` filters of `FILTER_SIZE` taps with zero "same" padding. Each result gets bias, arithmetic shift, saturation and optional ReLU. Results are emitted filter-major over a valid/ready stream. It replaces the fixed-size conv1d FIFO-recirculation prototype with real arithmetic, runtime-loadable weights and full backpressure.

---
 rtl/conv1d_pkg.sv | 39 +++
 rtl/conv1d_mac.sv | 29 ++
 rtl/conv1d_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the conv1d streaming engine: FSM states,
// accumulator sizing, configuration address map and output saturation.
package conv1d_pkg;

  typedef enum logic {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  // Widest intermediate handed to sat_relu; callers sign-extend into it.
  localparam int SAT_W = 64;

  function automatic int acc_width(input int bw, input int taps);
    return 2 * bw + $clog2(taps + 1) + 1;
  endfunction

  // Biases sit directly after the weight block in configuration space.
  function automatic int bias_base(input int num_filters, input int taps);
    return num_filters * taps;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] value,
    input int                      bw,
    input logic                    relu
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)      res = hi;
    else if (value < lo) res = lo;
    else                 res = value;
    if (relu && (res < 0)) res = '0;
    return res;
  endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Combinational signed dot product of N packed pairs plus a bias term.
// Shared by the conv1d engine and the dense layer.
module conv1d_mac
  import conv1d_pkg::*;
#(
  parameter int BW    = 8,
  parameter int N     = 3,
  parameter int ACC_W = acc_width(BW, N)
) (
  input  logic [N*BW-1:0]         x_vec,
  input  logic [N*BW-1:0]         w_vec,
  input  logic signed [BW-1:0]    bias,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*BW-1:0] prod;

  // NOTE: blocking assignments are correct here; each iteration must see the
  // running sum from the previous one within the same evaluation.
  always_comb begin
    acc  = ACC_W'(bias);
    prod = '0;
    for (int i = 0; i < N; i++) begin
      prod = $signed(x_vec[i*BW +: BW]) * $signed(w_vec[i*BW +: BW]);
      acc  = acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv1d_engine.sv
// Streaming 1-D convolution: buffers one frame, then emits NUM_FILTERS x
// FRAME_SIZE results (same zero padding, bias, shift, saturate, ReLU).
module conv1d_engine
  import conv1d_pkg::*;
#(
  parameter int BW          = 8,
  parameter int FRAME_SIZE  = 50,
  parameter int VECTOR_SIZE = 1,
  parameter int FILTER_SIZE = 3,
  parameter int NUM_FILTERS = 8,
  parameter int SHIFT       = 0,
  parameter int RELU        = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [VECTOR_SIZE*BW-1:0] data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic signed [BW-1:0]      data_o,
  output logic                      valid_o,
  output logic                      last_o,
  input  logic                      ready_i,
  input  logic                      cfg_we_i,
  input  logic [$clog2(NUM_FILTERS*(FILTER_SIZE*VECTOR_SIZE+1))-1:0] cfg_addr_i,
  input  logic signed [BW-1:0]      cfg_data_i,
  output logic                      frame_err_o
);

  localparam int TAPS  = FILTER_SIZE * VECTOR_SIZE;
  localparam int PAD   = (FILTER_SIZE - 1) / 2;
  localparam int NUM_W = bias_base(NUM_FILTERS, TAPS);
  localparam int ACC_W = acc_width(BW, TAPS);
  localparam int PW    = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int WIW   = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] t_q;
  logic [FW-1:0] f_q;

  logic [VECTOR_SIZE*BW-1:0] frame_q  [FRAME_SIZE];
  logic signed [BW-1:0]      weight_q [NUM_W];
  logic signed [BW-1:0]      bias_q   [NUM_FILTERS];

  logic [TAPS*BW-1:0]      x_win;
  logic [TAPS*BW-1:0]      w_win;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_shift;
  logic signed [BW-1:0]    result;

  logic accept, beat_full, frame_end, final_res, load_out;

  always_comb begin
    accept    = valid_i && (state_q == LOAD);
    beat_full = (wr_ptr_q == PW'(FRAME_SIZE - 1));
    frame_end = accept && (last_i || beat_full);
    final_res = (f_q == FW'(NUM_FILTERS - 1)) && (t_q == PW'(FRAME_SIZE - 1));
    load_out  = (state_q == COMPUTE) && (!valid_o || ready_i);
    state_d   = state_q;
    case (state_q)
      LOAD:    if (frame_end) state_d = COMPUTE;
      COMPUTE: if (load_out && final_res) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  assign ready_o = (state_q == LOAD);

  // Gather the window around t; taps falling outside the frame contribute 0.
  always_comb begin : window_mux
    int idx;
    x_win = '0;
    w_win = '0;
    for (int k = 0; k < FILTER_SIZE; k++) begin
      idx = int'(t_q) + k - PAD;
      for (int c = 0; c < VECTOR_SIZE; c++) begin
        w_win[(k*VECTOR_SIZE + c)*BW +: BW] =
          weight_q[WIW'(int'(f_q) * TAPS + k * VECTOR_SIZE + c)];
        if (idx >= 0 && idx < FRAME_SIZE)
          x_win[(k*VECTOR_SIZE + c)*BW +: BW] = frame_q[PW'(idx)][c*BW +: BW];
      end
    end
  end

  conv1d_mac #(
    .BW   (BW),
    .N    (TAPS),
    .ACC_W(ACC_W)
  ) u_mac (
    .x_vec(x_win),
    .w_vec(w_win),
    .bias (bias_q[f_q]),
    .acc  (acc)
  );

  assign acc_shift = acc >>> SHIFT;
  assign result    = BW'(sat_relu(SAT_W'(acc_shift), BW, RELU != 0));

  // NOTE: frame buffer and coefficient storage are register arrays that must
  // come out of reset as zero, so they are reset explicitly rather than left
  // to power-up contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      t_q         <= '0;
      f_q         <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      frame_err_o <= 1'b0;
      for (int i = 0; i < FRAME_SIZE; i++)  frame_q[i]  <= '0;
      for (int i = 0; i < NUM_W; i++)       weight_q[i] <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) bias_q[i]   <= '0;
    end else begin
      state_q     <= state_d;
      frame_err_o <= frame_end && !last_i;

      if (accept) begin
        frame_q[wr_ptr_q] <= data_i;
        wr_ptr_q          <= frame_end ? '0 : wr_ptr_q + PW'(1);
      end

      if (cfg_we_i && (state_q == LOAD)) begin
        if (int'(cfg_addr_i) < NUM_W)
          weight_q[WIW'(cfg_addr_i)] <= cfg_data_i;
        else if (int'(cfg_addr_i) < NUM_W + NUM_FILTERS)
          bias_q[FW'(int'(cfg_addr_i) - NUM_W)] <= cfg_data_i;
      end

      if (load_out) begin
        data_o  <= result;
        valid_o <= 1'b1;
        last_o  <= final_res;
        if (t_q == PW'(FRAME_SIZE - 1)) begin
          t_q <= '0;
          f_q <= final_res ? '0 : f_q + FW'(1);
        end else begin
          t_q <= t_q + PW'(1);
        end
        // Clearing on exit makes a short next frame read zeros past its end.
        if (final_res)
          for (int i = 0; i < FRAME_SIZE; i++) frame_q[i] <= '0;
      end else if (ready_i) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
    end
  end

endmodule
